seg14_scan_mux: RTL

// - Upstream feeder for the hex/ASCII-to-14-segment decoder. Holds a NUM_DIGITS-character display frame and time-multiplexes it onto one shared decoder.
// - Each scan slot drives one character's code, ascii flag and dp enable, plus a one-hot digit enable.
// - Thermostat control logic (temperature/mode text) loads frames through a valid/ready handshake.
// - A frame is swapped in only at a scan boundary, so the display never tears.

---
 rtl/seg14_scan_mux_pkg.sv | 22 ++
 rtl/seg14_scan_mux_if.sv | 27 ++
 rtl/seg14_scan_timer.sv | 60 ++++++
 rtl/seg14_scan_mux.sv | 81 ++++++++
 4 files changed

// File: rtl/seg14_scan_mux_pkg.sv
// Shared types and constants for the 14-segment scan multiplexer.
package seg14_scan_mux_pkg;

    localparam int unsigned SEG14_CHAR_W      = 7;
    localparam logic [6:0]  SEG14_ASCII_SPACE = 7'h20;

    typedef struct packed {
        logic [SEG14_CHAR_W-1:0] code;
        logic                    ascii;
        logic                    dp;
    } seg14_char_t;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_DRIVE = 1'b1
    } scan_phase_t;

    function automatic seg14_char_t space_char();
        return '{code: SEG14_ASCII_SPACE, ascii: 1'b1, dp: 1'b0};
    endfunction

endpackage

// File: rtl/seg14_scan_mux_if.sv
// Frame-load handshake plus decoder/digit drive bundle of the scan multiplexer.
interface seg14_scan_mux_if
    import seg14_scan_mux_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                                 i_frame_valid;
    logic                                 o_frame_ready;
    logic [SEG14_CHAR_W*NUM_DIGITS-1:0]   i_frame_chars;
    logic [NUM_DIGITS-1:0]                i_frame_ascii;
    logic [NUM_DIGITS-1:0]                i_frame_dp;
    logic [SEG14_CHAR_W-1:0]              o_data;
    logic                                 o_ascii;
    logic                                 o_dp_en;
    logic [NUM_DIGITS-1:0]                o_digit_en;
    logic                                 o_frame_sync;

    modport master (
        output i_frame_valid, i_frame_chars, i_frame_ascii, i_frame_dp,
        input  o_frame_ready, o_data, o_ascii, o_dp_en, o_digit_en, o_frame_sync
    );

    modport slave (
        input  i_frame_valid, i_frame_chars, i_frame_ascii, i_frame_dp,
        output o_frame_ready, o_data, o_ascii, o_dp_en, o_digit_en, o_frame_sync
    );
endinterface

// File: rtl/seg14_scan_timer.sv
// Slot counter, digit index and blank/drive phase; exposes next-cycle values
// so the top can register its outputs aligned with the counter.
module seg14_scan_timer
    import seg14_scan_mux_pkg::*;
#(
    parameter  int unsigned NUM_DIGITS = 4,
    parameter  int unsigned SCAN_DIV   = 2500,
    parameter  int unsigned BLANK_CYC  = 16,
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS),
    localparam int unsigned CNT_W      = $clog2(SCAN_DIV)
) (
    input  logic             clk,
    input  logic             reset,
    output logic [IDX_W-1:0] idx_nxt_c,
    output logic             slot_start_c,
    output logic             drive_nxt_c,
    output logic             boundary_c
);

    scan_phase_t      state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [IDX_W-1:0] idx_q, idx_nxt;

    // Reset parks on the last cycle of the last digit so release lands on digit 0, counter 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PH_DRIVE;
            cnt_q   <= CNT_W'(SCAN_DIV - 1);
            idx_q   <= IDX_W'(NUM_DIGITS - 1);
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            idx_q   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q + 1'b1;
        idx_nxt   = idx_q;
        case (state_q)
            PH_BLANK: begin
                if (cnt_q == CNT_W'(BLANK_CYC - 1)) state_nxt = PH_DRIVE;
            end
            PH_DRIVE: begin
                if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
                    state_nxt = PH_BLANK;
                    cnt_nxt   = '0;
                    idx_nxt   = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
                end
            end
        endcase
    end

    assign idx_nxt_c    = idx_nxt;
    assign slot_start_c = (cnt_q == CNT_W'(SCAN_DIV - 1));
    assign drive_nxt_c  = (state_nxt == PH_DRIVE);
    assign boundary_c   = slot_start_c && (idx_q == IDX_W'(NUM_DIGITS - 1));

endmodule

// File: rtl/seg14_scan_mux.sv
// Holds a display frame and time-multiplexes it onto one shared 14-segment
// decoder; new frames are swapped in only at the scan boundary.
module seg14_scan_mux
    import seg14_scan_mux_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 2500,
    parameter int unsigned BLANK_CYC  = 16
) (
    input logic             i_clk,
    input logic             i_reset,
    seg14_scan_mux_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

    logic [IDX_W-1:0] idx_nxt_c;
    logic             slot_start_c;
    logic             drive_nxt_c;
    logic             boundary_c;
    logic             swap_c;
    seg14_char_t      shown_c;

    seg14_char_t active  [NUM_DIGITS];
    seg14_char_t pending [NUM_DIGITS];

    seg14_scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .BLANK_CYC  (BLANK_CYC)
    ) u_timer (
        .clk          (i_clk),
        .reset        (i_reset),
        .idx_nxt_c    (idx_nxt_c),
        .slot_start_c (slot_start_c),
        .drive_nxt_c  (drive_nxt_c),
        .boundary_c   (boundary_c)
    );

    // Ready low means the pending buffer holds a frame waiting for the boundary.
    assign swap_c  = boundary_c && !bus.o_frame_ready;
    assign shown_c = swap_c ? pending[idx_nxt_c] : active[idx_nxt_c];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                active[k]  <= space_char();
                pending[k] <= space_char();
            end
            bus.o_frame_ready <= 1'b1;
            bus.o_data        <= SEG14_ASCII_SPACE;
            bus.o_ascii       <= 1'b1;
            bus.o_dp_en       <= 1'b0;
            bus.o_digit_en    <= '0;
            bus.o_frame_sync  <= 1'b0;
        end else begin
            // A swap needs ready low, so it never coincides with an accept.
            if (swap_c) begin
                for (int k = 0; k < NUM_DIGITS; k++) active[k] <= pending[k];
                bus.o_frame_ready <= 1'b1;
            end else if (bus.i_frame_valid && bus.o_frame_ready) begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    pending[k] <= '{code:  bus.i_frame_chars[SEG14_CHAR_W*k +: SEG14_CHAR_W],
                                    ascii: bus.i_frame_ascii[k],
                                    dp:    bus.i_frame_dp[k]};
                end
                bus.o_frame_ready <= 1'b0;
            end

            bus.o_frame_sync <= slot_start_c && (idx_nxt_c == '0);
            bus.o_digit_en   <= drive_nxt_c ? (NUM_DIGITS'(1) << idx_nxt_c) : '0;

            if (slot_start_c) begin
                bus.o_data  <= shown_c.code;
                bus.o_ascii <= shown_c.ascii;
                bus.o_dp_en <= shown_c.dp;
            end
        end
    end

endmodule
